// File: rtl/uart_rx_cfg.sv
// UART receiver, runtime frame format (5-8 data, none/even/odd parity, 1/2 stop), 16x majority sampling.
// data_valid fires one cycle after the final stop-bit majority point; no backpressure, consumer must take it.
module uart_rx_cfg #(
   parameter int CLK_FREQ    = 100000000,
   parameter int OVERSAMPLE  = 16,
   parameter int SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [2:0] Baud_Set,
   input  logic [1:0] data_bits,
   input  logic [1:0] parity_mode,
   input  logic       stop_bits,
   input  logic       rx,
   output logic [7:0] data,
   output logic       data_valid,
   output logic       rx_busy,
   output logic       parity_err,
   output logic       frame_err,
   output logic       break_det
);

   localparam int OS_W = $clog2(OVERSAMPLE);
   localparam int M    = OVERSAMPLE / 2;
   localparam logic [OS_W-1:0] OS_S0   = OS_W'(M - 1);
   localparam logic [OS_W-1:0] OS_S1   = OS_W'(M);
   localparam logic [OS_W-1:0] OS_S2   = OS_W'(M + 1);
   localparam logic [OS_W-1:0] OS_LAST = OS_W'(OVERSAMPLE - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP1,
      S_STOP2
   } state_t;

   state_t state, state_nxt;

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   rx_s, rx_s_d;
   logic                   start_edge;

   logic [15:0]     div_sel, div_q, div_cnt;
   logic [OS_W-1:0] os_cnt;
   logic            busy, os_tick, maj_tick, end_tick;
   logic            smp0, smp1, maj;

   logic [1:0] nbits_q;
   logic       par_en_q, par_odd_q, two_stop_q;
   logic [7:0] shreg;
   logic [2:0] bit_idx;
   logic       par_bit_q, stop1_q;
   logic       resolve, stop1_v, stop2_v, par_calc;

   assign rx_s       = sync_q[SYNC_STAGES-1];
   assign start_edge = rx_s_d & ~rx_s;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '1;
         rx_s_d <= 1'b1;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], rx};
         rx_s_d <= rx_s;
      end
   end

   // Constant per-baud divisors; only the select mux is built.
   always_comb begin
      div_sel = 16'(CLK_FREQ / (9600 * OVERSAMPLE));
      case (Baud_Set)
         3'd0: div_sel = 16'(CLK_FREQ / (9600 * OVERSAMPLE));
         3'd1: div_sel = 16'(CLK_FREQ / (19200 * OVERSAMPLE));
         3'd2: div_sel = 16'(CLK_FREQ / (38400 * OVERSAMPLE));
         3'd3: div_sel = 16'(CLK_FREQ / (57600 * OVERSAMPLE));
         3'd4: div_sel = 16'(CLK_FREQ / (115200 * OVERSAMPLE));
         3'd5: div_sel = 16'(CLK_FREQ / (230400 * OVERSAMPLE));
         3'd6: div_sel = 16'(CLK_FREQ / (460800 * OVERSAMPLE));
         3'd7: div_sel = 16'(CLK_FREQ / (921600 * OVERSAMPLE));
         default: div_sel = 16'(CLK_FREQ / (9600 * OVERSAMPLE));
      endcase
   end

   assign busy     = (state != S_IDLE);
   assign rx_busy  = busy;
   assign os_tick  = busy && (div_cnt == div_q - 16'd1);
   assign maj_tick = os_tick && (os_cnt == OS_S2);
   assign end_tick = os_tick && (os_cnt == OS_LAST);
   assign maj      = (smp0 & smp1) | (smp0 & rx_s) | (smp1 & rx_s);

   // Frame closes at the last stop bit's majority point, not its end, so back-to-back frames fit.
   assign resolve  = maj_tick && ((state == S_STOP1 && !two_stop_q) || state == S_STOP2);
   assign stop1_v  = (state == S_STOP1) ? maj : stop1_q;
   assign stop2_v  = (state == S_STOP2) ? maj : 1'b1;
   assign par_calc = (^shreg) ^ par_odd_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:   if (start_edge) state_nxt = S_START;
         S_START:  if (maj_tick && maj) state_nxt = S_IDLE;
                   else if (end_tick)   state_nxt = S_DATA;
         S_DATA:   if (end_tick && bit_idx == {1'b1, nbits_q})
                      state_nxt = par_en_q ? S_PARITY : S_STOP1;
         S_PARITY: if (end_tick) state_nxt = S_STOP1;
         S_STOP1:  if (maj_tick && !two_stop_q) state_nxt = S_IDLE;
                   else if (end_tick)           state_nxt = S_STOP2;
         S_STOP2:  if (maj_tick) state_nxt = S_IDLE;
         default:  state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_q      <= '0;
         nbits_q    <= '0;
         par_en_q   <= 1'b0;
         par_odd_q  <= 1'b0;
         two_stop_q <= 1'b0;
         div_cnt    <= '0;
         os_cnt     <= '0;
         smp0       <= 1'b1;
         smp1       <= 1'b1;
         shreg      <= '0;
         bit_idx    <= '0;
         par_bit_q  <= 1'b0;
         stop1_q    <= 1'b1;
         data       <= '0;
         data_valid <= 1'b0;
         parity_err <= 1'b0;
         frame_err  <= 1'b0;
         break_det  <= 1'b0;
      end else begin
         data_valid <= 1'b0;
         if (state == S_IDLE) begin
            div_cnt <= '0;
            os_cnt  <= '0;
            if (start_edge) begin
               div_q      <= div_sel;
               nbits_q    <= data_bits;
               par_en_q   <= ^parity_mode;
               par_odd_q  <= parity_mode[1];
               two_stop_q <= stop_bits;
               shreg      <= '0;
               bit_idx    <= '0;
            end
         end else begin
            div_cnt <= os_tick ? '0 : div_cnt + 16'd1;
            if (os_tick) begin
               os_cnt <= (os_cnt == OS_LAST) ? '0 : os_cnt + 1'b1;
               if (os_cnt == OS_S0) smp0 <= rx_s;
               if (os_cnt == OS_S1) smp1 <= rx_s;
            end
            if (maj_tick) begin
               case (state)
                  S_DATA:   shreg[bit_idx] <= maj;
                  S_PARITY: par_bit_q      <= maj;
                  S_STOP1:  stop1_q        <= maj;
                  default:  ;
               endcase
            end
            if (end_tick && state == S_DATA) bit_idx <= bit_idx + 3'd1;
            if (resolve) begin
               data_valid <= 1'b1;
               data       <= shreg;
               parity_err <= par_en_q & (par_bit_q ^ par_calc);
               frame_err  <= ~stop1_v | ~stop2_v;
               break_det  <= (shreg == 8'd0) & ~(par_en_q & par_bit_q) & ~stop1_v;
            end
         end
      end
   end

endmodule

// File: doc/uart_rx_cfg.md
Name: uart_rx_cfg

Overview:
Next-generation UART receiver with runtime-configurable frame format: 5–8 data bits, none/even/odd parity, and 1 or 2 stop bits. It adds 16x oversampling with 3-sample majority voting, false-start rejection, and parity, framing and break error reporting. It sits between the board-level rx pin and the same downstream consumers as the existing receiver (byte sink / BRAM writer). It extends the baud table to 921600.

Parameters:
CLK_FREQ, 100000000, system clock frequency in Hz.
OVERSAMPLE, 16, oversample ticks per bit; must be even and at least 8.
SYNC_STAGES, 2, flip-flop stages in the rx input synchroniser; must be at least 2.

Ports:
clk  input  1  system clock; all logic on its rising edge.
rst_n  input  1  asynchronous active-low reset.
Baud_Set  input  3  baud select: 0=9600, 1=19200, 2=38400, 3=57600, 4=115200, 5=230400, 6=460800, 7=921600.
data_bits  input  2  data bits per frame: 00=5, 01=6, 10=7, 11=8.
parity_mode  input  2  parity: 00=none, 01=even, 10=odd, 11=none.
stop_bits  input  1  stop bits: 0=one, 1=two.
rx  input  1  asynchronous serial line; idles high.
data  output  8  received word, LSB-first, right-justified; unused upper bits are 0.
data_valid  output  1  one-cycle pulse when data and the error flags are updated.
rx_busy  output  1  high from start-edge detect until return to IDLE.
parity_err  output  1  parity mismatch in the last frame.
frame_err  output  1  any stop bit sampled low in the last frame.
break_det  output  1  last frame was all zeros, including parity and the first stop bit.

Behaviour:
- Reset values: all outputs 0, FSM in IDLE. The synchroniser resets to 1, so reset release never reads as a start edge. Reset mid-frame aborts the frame immediately and emits no data_valid.
- Synchroniser: rx passes through SYNC_STAGES flops. A start edge is synced-high followed by synced-low on consecutive cycles.
- Divisor: DIV = CLK_FREQ/(baud*OVERSAMPLE), integer division, 16-bit. DIV, data_bits, parity_mode and stop_bits are latched on start detect. Changing these inputs mid-frame has no effect until the next frame.
- Tick generator:
  - div_cnt counts 0..DIV-1 only while busy.
  - os_tick pulses when div_cnt==DIV-1.
  - os_cnt counts os_ticks 0..OVERSAMPLE-1 within a bit.
  - Both counters clear on start detect and in IDLE.
- Sampling: on os_tick with os_cnt equal to M-1, M and M+1 (M=OVERSAMPLE/2), the synced rx is sampled. The bit value is the majority of the 3 samples, resolved at the os_cnt==M+1 tick.
- Bit end: on os_tick with os_cnt==OVERSAMPLE-1, os_cnt wraps to 0 and the FSM advances.
- FSM:
  - IDLE: on start edge, go to START and set rx_busy=1 on the next cycle.
  - START: if the majority value is 1, it is a false start; go to IDLE, drop rx_busy, no data_valid. If 0, go to DATA at bit end.
  - DATA: shift majority values in LSB-first. After N bits, go to PARITY if parity is enabled, else STOP1.
  - PARITY: compare the majority bit with the computed parity. Even: XOR of data bits. Odd: its inverse.
  - STOP1: if stop_bits=0, resolve the frame at the majority point. If stop_bits=1, go to STOP2 at bit end.
  - STOP2: resolve the frame at the majority point.
- Frame resolution (on the cycle after the final stop majority tick):
  - data_valid=1 for exactly one cycle.
  - data, parity_err, frame_err and break_det all update in that same cycle.
  - FSM returns to IDLE and rx_busy drops in that cycle.
  - The remaining half stop bit is not waited for, which allows back-to-back frames.
- Flag rules:
  - parity_err is 0 when parity is disabled.
  - frame_err=1 if either stop bit majority is 0.
  - break_det=1 if all data bits, the parity bit (if enabled) and STOP1 are 0; it implies frame_err=1.
- data and all flags hold their values until the next data_valid.
- After a low stop bit, a new frame starts only after the line is seen high and then falls again, so a held break produces exactly one frame.

Test Plan:
- Baud_Set=4, 8N1, send 0xA5 → data=0xA5, a single-cycle data_valid about 9.5 bit times after the start edge, all error flags 0.
- Baud_Set=0, 7E2, send 0x35 with correct parity bit 0 → data=0x35, parity_err=0. Repeat with parity bit 1 → data=0x35, parity_err=1.
- 8O1, then 5N1, at Baud_Set=7 (DIV=6), send 0x00 and 0x1F back-to-back with zero idle → two valid pulses; data=0x00 then 0x1F, upper bits 0.
- Glitch: rx low for 4 oversample ticks at Baud_Set=4 → rx_busy rises then falls at the start majority point, no data_valid, outputs unchanged.
- 8N1 with stop bit forced low → frame_err=1, break_det=0. Hold rx low for 20 bit times → one valid, data=0x00, break_det=1, no further frame until rx returns high.
- Assert rst_n low mid-DATA → all outputs 0 immediately, no data_valid. Release rst_n and send 0x3C → clean reception, data=0x3C.
